// File: rtl/timer_registers_pkg.sv
// Shared constants for the timer/counter register window: word width,
// word indices on the flat register bus and status bit positions.
package timer_registers_pkg;

  localparam int WORD_W    = 32;
  localparam int TMR_WORDS = 4;

  localparam int TMR_W_SNAP_LO = 0;
  localparam int TMR_W_SNAP_HI = 1;
  localparam int TMR_W_COUNT   = 2;
  localparam int TMR_W_STATUS  = 3;

  localparam int TMR_ST_EXPIRED = 0;
  localparam int TMR_ST_RUNNING = 1;
  localparam int TMR_ST_WRAP    = 2;
  localparam int TMR_ST_AUTO    = 3;

  // Assemble the status word; unused upper bits read as zero.
  function automatic logic [WORD_W-1:0] pack_status(input logic expired,
                                                    input logic running,
                                                    input logic wrap,
                                                    input logic auto_rl);
    logic [WORD_W-1:0] s;
    s                 = '0;
    s[TMR_ST_EXPIRED] = expired;
    s[TMR_ST_RUNNING] = running;
    s[TMR_ST_WRAP]    = wrap;
    s[TMR_ST_AUTO]    = auto_rl;
    return s;
  endfunction

endpackage

// File: rtl/timer_registers_tick_divider.sv
// Prescaler: counts enabled cycles and asserts tick on the cycle where the
// count reaches PRESCALE-1, then wraps back to zero.
module tick_divider #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  // A 1-bit counter is kept even for PRESCALE=1 so the compare is always legal.
  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CNT_W-1:0] count_q, count_d;

  // Tick is a pure decode of the registered count while enabled.
  always_comb begin
    tick    = enable && (count_q == CNT_W'(PRESCALE - 1));
    count_d = count_q;
    if (clear)       count_d = '0;
    else if (tick)   count_d = '0;
    else if (enable) count_d = count_q + CNT_W'(1);
  end

  // Prescale count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/timer_registers.sv
// Timer/counter core: free-running 64-bit cycle counter with tear-free
// snapshot, prescaled countdown with optional auto-reload, sticky status.
module timer_registers
  import timer_registers_pkg::*;
#(
  parameter int unsigned       PRESCALE   = 1,
  parameter logic [WORD_W-1:0] RESET_LOAD = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_snapshot,
  input  logic                        i_load_valid,
  input  logic [WORD_W-1:0]           i_load_value,
  input  logic                        i_start,
  input  logic                        i_stop,
  input  logic                        i_auto_reload,
  input  logic                        i_clear_status,
  output logic [TMR_WORDS*WORD_W-1:0] o_registers,
  output logic                        o_irq
);

  logic [63:0]       cyc_q, cyc_d;
  logic [63:0]       snap_q, snap_d;
  logic [WORD_W-1:0] value_q, value_d;
  logic [WORD_W-1:0] reload_q, reload_d;
  logic              running_q, running_d;
  logic              expired_q, expired_d;
  logic              wrap_q, wrap_d;
  logic              auto_q, auto_d;
  logic              irq_q, irq_d;
  logic              tick;
  logic              expire;

  // Stop and load both restart the prescale phase from zero.
  tick_divider #(.PRESCALE(PRESCALE)) u_div (
    .clk    (clk),
    .reset  (reset),
    .enable (running_q),
    .clear  (i_load_valid | i_stop),
    .tick   (tick)
  );

  // Next-state logic; a load in the same cycle swallows the tick.
  always_comb begin
    expire = tick && !i_load_valid && (value_q <= WORD_W'(1));

    cyc_d  = cyc_q + 64'd1;
    wrap_d = (wrap_q && !i_clear_status) || (&cyc_q);
    snap_d = i_snapshot ? cyc_q : snap_q;

    reload_d = i_load_valid ? i_load_value : reload_q;
    value_d  = value_q;
    if (i_load_valid)      value_d = i_load_value;
    else if (expire)       value_d = i_auto_reload ? reload_q : '0;
    else if (tick)         value_d = value_q - WORD_W'(1);

    running_d = running_q;
    if (i_stop)                         running_d = 1'b0;
    else if (expire && !i_auto_reload)  running_d = 1'b0;
    else if (i_start)                   running_d = 1'b1;

    expired_d = (expired_q && !i_clear_status) || expire;
    auto_d    = i_auto_reload;
    irq_d     = expire;
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q     <= '0;
      snap_q    <= '0;
      value_q   <= RESET_LOAD;
      reload_q  <= RESET_LOAD;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      wrap_q    <= 1'b0;
      auto_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      cyc_q     <= cyc_d;
      snap_q    <= snap_d;
      value_q   <= value_d;
      reload_q  <= reload_d;
      running_q <= running_d;
      expired_q <= expired_d;
      wrap_q    <= wrap_d;
      auto_q    <= auto_d;
      irq_q     <= irq_d;
    end
  end

  // Flat register bus seen by the read-only window.
  always_comb begin
    o_registers = '0;
    o_registers[TMR_W_SNAP_LO*WORD_W +: WORD_W] = snap_q[31:0];
    o_registers[TMR_W_SNAP_HI*WORD_W +: WORD_W] = snap_q[63:32];
    o_registers[TMR_W_COUNT*WORD_W   +: WORD_W] = value_q;
    o_registers[TMR_W_STATUS*WORD_W  +: WORD_W] =
      pack_status(expired_q, running_q, wrap_q, auto_q);
  end

  assign o_irq = irq_q;

endmodule

// File: tb/tb_timer_registers.sv
// Directed bench for timer_registers at PRESCALE=4, RESET_LOAD=6.
module tb_timer_registers;
  import timer_registers_pkg::*;

  localparam logic [31:0] RL = 32'd6;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_snapshot, i_load_valid, i_start, i_stop;
  logic        i_auto_reload, i_clear_status;
  logic [31:0] i_load_value;
  logic [TMR_WORDS*WORD_W-1:0] o_registers;
  logic        o_irq;
  logic [31:0] w0, w1, w2, w3;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        ld;
    logic [31:0] v;
    logic        st, sp, au, cl;
    logic [31:0] e_w2, e_w3;
    logic        e_irq;
  } vec_t;

  vec_t vecs[$];

  timer_registers #(.PRESCALE(4), .RESET_LOAD(RL)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_snapshot     (i_snapshot),
    .i_load_valid   (i_load_valid),
    .i_load_value   (i_load_value),
    .i_start        (i_start),
    .i_stop         (i_stop),
    .i_auto_reload  (i_auto_reload),
    .i_clear_status (i_clear_status),
    .o_registers    (o_registers),
    .o_irq          (o_irq)
  );

  always #5 clk = ~clk;

  assign w0 = o_registers[31:0];
  assign w1 = o_registers[63:32];
  assign w2 = o_registers[95:64];
  assign w3 = o_registers[127:96];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic ld, input logic [31:0] v, input logic st,
                     input logic sp, input logic au, input logic cl,
                     input logic [31:0] e2, input logic [31:0] e3, input logic ei);
    vec_t t;
    t.ld = ld; t.v = v; t.st = st; t.sp = sp; t.au = au; t.cl = cl;
    t.e_w2 = e2; t.e_w3 = e3; t.e_irq = ei;
    vecs.push_back(t);
  endtask

  task automatic idle(input int n, input logic au, input logic [31:0] e2,
                      input logic [31:0] e3);
    for (int k = 0; k < n; k++) add(0, 0, 0, 0, au, 0, e2, e3, 0);
  endtask

  task automatic clr_inputs();
    i_snapshot = 0; i_load_valid = 0; i_load_value = '0; i_start = 0;
    i_stop = 0; i_auto_reload = 0; i_clear_status = 0;
  endtask

  initial begin
    // one-shot countdown: load 3, ticks every 4 cycles, expiry on 3rd tick
    add(1, 3, 0, 0, 0, 0, 3, 32'h0, 0);
    add(0, 0, 1, 0, 0, 0, 3, 32'h2, 0);
    idle(3, 0, 3, 32'h2);
    idle(4, 0, 2, 32'h2);
    idle(4, 0, 1, 32'h2);
    add(0, 0, 0, 0, 0, 0, 0, 32'h1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 32'h1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 32'h0, 0);
    // auto-reload: load 2, expiry every 8 cycles
    add(1, 2, 0, 0, 1, 0, 2, 32'h8, 0);
    add(0, 0, 1, 0, 1, 0, 2, 32'hA, 0);
    idle(3, 1, 2, 32'hA);
    idle(4, 1, 1, 32'hA);
    add(0, 0, 0, 0, 1, 0, 2, 32'hB, 1);
    idle(3, 1, 2, 32'hB);
    idle(4, 1, 1, 32'hB);
    add(0, 0, 0, 0, 1, 0, 2, 32'hB, 1);
    add(0, 0, 0, 1, 1, 0, 2, 32'h9, 0);
    add(0, 0, 1, 1, 1, 0, 2, 32'h9, 0);   // stop wins over start
    add(0, 0, 0, 0, 0, 1, 2, 32'h0, 0);
    // load on a tick edge: no decrement, prescale phase restarts
    add(1, 4, 0, 0, 0, 0, 4, 32'h0, 0);
    add(0, 0, 1, 0, 0, 0, 4, 32'h2, 0);
    idle(3, 0, 4, 32'h2);
    add(1, 5, 0, 0, 0, 0, 5, 32'h2, 0);
    idle(3, 0, 5, 32'h2);
    idle(1, 0, 4, 32'h2);
    add(0, 0, 0, 1, 0, 0, 4, 32'h0, 0);
    // clear_status in the expiry cycle: expired stays set
    add(1, 1, 0, 0, 0, 0, 1, 32'h0, 0);
    add(0, 0, 1, 0, 0, 0, 1, 32'h2, 0);
    idle(3, 0, 1, 32'h2);
    add(0, 0, 0, 0, 0, 1, 0, 32'h1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 32'h1, 0);
    // start while running keeps the prescale count
    add(1, 3, 0, 0, 0, 1, 3, 32'h0, 0);
    add(0, 0, 1, 0, 0, 0, 3, 32'h2, 0);
    idle(2, 0, 3, 32'h2);
    add(0, 0, 1, 0, 0, 0, 3, 32'h2, 0);
    idle(1, 0, 2, 32'h2);
    add(0, 0, 0, 1, 0, 0, 2, 32'h0, 0);
    // start with value 0 expires at the first tick
    add(1, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 32'h2, 0);
    idle(3, 0, 0, 32'h2);
    add(0, 0, 0, 0, 0, 0, 0, 32'h1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 32'h1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 32'h0, 0);

    // reset and snapshot at the 10th cycle after release
    clr_inputs();
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst w0", w0, 0);
    chk("rst w1", w1, 0);
    chk("rst w2", w2, RL);
    chk("rst w3", w3, 0);
    chk("rst irq", o_irq, 0);
    reset = 0;
    repeat (9) @(posedge clk);
    #1 i_snapshot = 1;
    step();
    i_snapshot = 0;
    chk("snap w0", w0, 9);
    chk("snap w1", w1, 0);
    chk("snap w2", w2, RL);
    chk("snap w3", w3, 0);
    chk("snap irq", o_irq, 0);

    // table-driven sequences
    foreach (vecs[i]) begin
      i_load_valid   = vecs[i].ld;
      i_load_value   = vecs[i].v;
      i_start        = vecs[i].st;
      i_stop         = vecs[i].sp;
      i_auto_reload  = vecs[i].au;
      i_clear_status = vecs[i].cl;
      step();
      chk($sformatf("vec%0d w2", i), w2, vecs[i].e_w2);
      chk($sformatf("vec%0d w3", i), w3, vecs[i].e_w3);
      chk($sformatf("vec%0d irq", i), o_irq, vecs[i].e_irq);
    end
    clr_inputs();

    // cycle counter wrap
    force dut.cyc_q = 64'hFFFF_FFFF_FFFF_FFFE;
    @(negedge clk);
    release dut.cyc_q;
    repeat (3) @(posedge clk);
    #1 i_snapshot = 1;
    step();
    i_snapshot = 0;
    chk("wrap snap", {w1, w0}, 64'h1);
    chk("wrap w3", w3, 32'h4);
    i_clear_status = 1;
    step();
    i_clear_status = 0;
    chk("wrap clear w3", w3, 32'h0);

    // reset two cycles into a running countdown
    i_load_valid = 1; i_load_value = 2;
    step();
    i_load_valid = 0; i_start = 1;
    step();
    i_start = 0;
    step();
    step();
    reset = 1;
    step();
    reset = 0;
    chk("midrst w0", w0, 0);
    chk("midrst w1", w1, 0);
    chk("midrst w2", w2, RL);
    chk("midrst w3", w3, 0);
    chk("midrst irq", o_irq, 0);
    for (int k = 0; k < 30; k++) begin
      step();
      chk("midrst no irq", o_irq, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_registers.md
Name: timer_registers

Overview:
- Timer/counter peripheral core that sits directly upstream of the processor's read-only register window.
- Maintains a free-running 64-bit cycle counter, a prescaled countdown timer and a status word.
- Presents all four words as a flat bus, o_registers, which the register window decodes for processor loads.
- Control arrives as single-cycle strobes from the peripheral's write-side decode logic.

Parameters:
- PRESCALE, 1, countdown ticks once every PRESCALE clk cycles while running; legal range 1..2^16.
- RESET_LOAD, 0, reset value of the countdown value and reload registers.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- i_snapshot  input  1  strobe: latch the cycle counter into words 0/1.
- i_load_valid  input  1  strobe: load countdown value and reload register from i_load_value.
- i_load_value  input  WORD_W  countdown load value.
- i_start  input  1  strobe: set running.
- i_stop  input  1  strobe: clear running and the prescale count.
- i_auto_reload  input  1  level: on expiry, reload and keep running.
- i_clear_status  input  1  strobe: clear the sticky status bits.
- o_registers  output  4*WORD_W  word k occupies bits [(k+1)*WORD_W-1 : k*WORD_W].
- o_irq  output  1  one-cycle pulse on expiry.

Behaviour:
- Single clock domain. All state is registered. reset is synchronous and active-high and is sampled only on the rising clk edge.
- Reset values:
  - Cycle counter = 0; snapshot words = 0.
  - Countdown value and reload register = RESET_LOAD.
  - Prescale count = 0; running = 0; all status bits = 0; o_irq = 0.
- A reset asserted mid-countdown aborts it with no o_irq and no status set.
- Word map:
  - w0 = snapshot[31:0]
  - w1 = snapshot[63:32]
  - w2 = current countdown value
  - w3 = status: bit0 expired (sticky), bit1 running, bit2 cyc_wrap (sticky), bit3 = registered copy of i_auto_reload; bits 31:4 = 0.
- Cycle counter:
  - Increments by 1 every cycle when not in reset.
  - At 2^64-1 it wraps to 0 and sets cyc_wrap.
- Snapshot:
  - i_snapshot captures the counter value present before that edge's increment.
  - Visible on w0/w1 one cycle later, and w0/w1 always come from the same edge (no torn reads).
- Prescale count:
  - Advances only while running.
  - A tick is asserted in the cycle where the count == PRESCALE-1; the count then returns to 0.
  - With PRESCALE=1, the timer ticks every running cycle.
- Countdown on a tick:
  - If value > 1: value decrements by 1.
  - If value <= 1 (expiry): expired is set and o_irq pulses high in the next cycle for exactly 1 cycle.
  - On expiry with i_auto_reload=1: value <= reload register and running stays 1.
  - On expiry with i_auto_reload=0: value <= 0 and running <= 0.
  - A start with value 0 therefore expires at the first tick.
- Load:
  - Writes both the value and the reload register and clears the prescale count.
  - Does not change running.
- Same-cycle priorities:
  - load over tick: the tick is discarded.
  - stop over start: result is stopped.
  - Start while already running: no effect (the prescale count is kept).
  - An expiry set over i_clear_status: expired stays 1. cyc_wrap follows the same rule.
- Latency: every strobe's effect is visible on o_registers one cycle after the edge that samples it.

Decomposition:
- Shared header timer_regs.vh holds:
  - Word indices: TMR_W_SNAP_LO=0, TMR_W_SNAP_HI=1, TMR_W_COUNT=2, TMR_W_STATUS=3.
  - Status bit positions: TMR_ST_EXPIRED=0, TMR_ST_RUNNING=1, TMR_ST_WRAP=2, TMR_ST_AUTO=3.
  - TMR_WORDS=4.
- WORD_W comes from config.vh.
- One sub-module, tick_divider: the prescaler. Inputs clk, reset, enable, clear; output tick; parameter PRESCALE.

Test Plan:
- Reset held for 3 cycles, then released; i_snapshot pulsed on the 10th cycle after release -> w0=9 and w1=0 one cycle later; w2=RESET_LOAD, w3=0, o_irq=0.
- PRESCALE=4, load 3, start, i_auto_reload=0 -> w2 steps 3,2 on ticks 4 cycles apart; on the 3rd tick w2=0, status=0x1, o_irq high for 1 cycle, running cleared.
- i_auto_reload=1, load 2, start -> expiries every 8 cycles at PRESCALE=4; w2 reloads to 2; status bit1 stays 1; one o_irq pulse per expiry.
- Counter forced to 0xFFFF_FFFF_FFFF_FFFE via hierarchical force, then released; snapshot after 3 cycles -> w1:w0 = 0x0000_0000_0000_0001 and status bit2 = 1; then i_clear_status -> bit2 = 0.
- Same-cycle events:
  - i_load_valid with value 5 on a tick edge -> w2=5 with no decrement.
  - i_start with i_stop -> running=0.
  - i_clear_status in the expiry cycle -> expired=1.
- Reset asserted two cycles into a running countdown -> next cycle all words = reset values, o_irq never pulses.
